// File: rtl/mmio_timer_responder_if.sv
// Purpose: data-memory bus seen by the timer (core request side plus responder outputs).
// Latency: n/a (signal bundle only).
// Backpressure: none; the single-cycle core never stalls the bus.
interface mmio_timer_responder_if;
   logic        Mem_Write_i;
   logic        Mem_Read_i;
   logic [31:0] Address_i;
   logic [31:0] Write_Data_i;
   logic [31:0] Read_Data_o;
   logic        Select_o;
   logic        Irq_o;

   // core drives requests, receives load data / select / interrupt
   modport master (
      output Mem_Write_i, Mem_Read_i, Address_i, Write_Data_i,
      input  Read_Data_o, Select_o, Irq_o
   );

   // timer receives requests, drives load data / select / interrupt
   modport slave (
      input  Mem_Write_i, Mem_Read_i, Address_i, Write_Data_i,
      output Read_Data_o, Select_o, Irq_o
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Purpose: memory-mapped down-counting timer in a 32-byte window; optional prescaler under TIMER_PRESCALER_EN.
// Latency: loads return data combinationally in the same cycle; stores commit at the next rising edge.
// Backpressure: none; every request is accepted in the cycle it is presented.
module mmio_timer_responder #(
   parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000
) (
   input logic                   clk,
   input logic                   reset,
   mmio_timer_responder_if.slave bus
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_LOAD   = 3'd1;
   localparam logic [2:0] OFF_COUNT  = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_PRE    = 3'd4;

   logic        r_en;
   logic        r_ar;
   logic        r_ie;
   logic        r_exp;
   logic [31:0] r_load;
   logic [31:0] r_count;

   logic        w_sel;
   logic        w_wr;
   logic [2:0]  w_off;
   logic        w_tick;
   logic        w_expire;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_sel    = (bus.Address_i[31:5] == BASE_ADDRESS[31:5]);
   assign w_wr     = bus.Mem_Write_i & w_sel;
   assign w_off    = bus.Address_i[4:2];
   assign w_expire = w_tick && (r_count == 32'd0);
   // byte-lane bits are ignored: the window is word-access only
   assign w_unused = ^bus.Address_i[1:0];

`ifdef TIMER_PRESCALER_EN
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;

   // one tick each time the prescaler counter reaches PRESCALE
   assign w_tick = r_en && (r_pcnt == r_prescale);

   // prescaler divisor register and free-running divider, parked at 0 while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prescale <= 16'd0;
         r_pcnt     <= 16'd0;
      end else begin
         if (!r_en || w_tick)
            r_pcnt <= 16'd0;
         else
            r_pcnt <= r_pcnt + 16'd1;
         if (w_wr && w_off == OFF_PRE) begin
            r_prescale <= bus.Write_Data_i[15:0];
            r_pcnt     <= 16'd0;
         end
      end
   end
`else
   assign w_tick = r_en;
`endif

   // CTRL bits; a software CTRL write overrides the one-shot auto-disable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en <= 1'b0;
         r_ar <= 1'b0;
         r_ie <= 1'b0;
      end else begin
         if (w_expire && !r_ar)
            r_en <= 1'b0;
         if (w_wr && w_off == OFF_CTRL) begin
            r_en <= bus.Write_Data_i[0];
            r_ar <= bus.Write_Data_i[1];
            r_ie <= bus.Write_Data_i[2];
         end
      end
   end

   // LOAD register; COUNT follows a LOAD write only while the timer is stopped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_load  <= 32'd0;
         r_count <= 32'd0;
      end else begin
         if (w_tick) begin
            if (r_count != 32'd0)
               r_count <= r_count - 32'd1;
            else if (r_ar)
               r_count <= r_load;
         end
         if (w_wr && w_off == OFF_LOAD) begin
            r_load <= bus.Write_Data_i;
            if (!r_en)
               r_count <= bus.Write_Data_i;
         end
      end
   end

   // EXP sticky flag: write-1-clear, with a same-cycle expire taking priority
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_exp <= 1'b0;
      end else begin
         if (w_wr && w_off == OFF_STATUS && bus.Write_Data_i[0])
            r_exp <= 1'b0;
         if (w_expire)
            r_exp <= 1'b1;
      end
   end

   // combinational load-data mux, zero when not addressed
   always_comb begin
      w_rdata = 32'd0;
      if (bus.Mem_Read_i && w_sel) begin
         case (w_off)
            OFF_CTRL:   w_rdata = {29'd0, r_ie, r_ar, r_en};
            OFF_LOAD:   w_rdata = r_load;
            OFF_COUNT:  w_rdata = r_count;
            OFF_STATUS: w_rdata = {31'd0, r_exp};
`ifdef TIMER_PRESCALER_EN
            OFF_PRE:    w_rdata = {16'd0, r_prescale};
`endif
            default:    w_rdata = 32'd0;
         endcase
      end
   end

   assign bus.Read_Data_o = w_rdata;
   assign bus.Select_o    = w_sel;
   assign bus.Irq_o       = r_exp & r_ie;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Purpose: directed plus random stimulus for the MMIO timer against a reference model.
// Latency: bus ops issued at the falling edge, outputs sampled 1ns later, model advanced at the rising edge.
// Backpressure: none to model; one bus operation per clock.
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   mmio_timer_responder_if bus();

   mmio_timer_responder #(.BASE_ADDRESS(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic        m_en, m_ar, m_ie, m_exp;
   logic [31:0] m_load, m_count;
   logic [15:0] m_pre, m_phase;

   task automatic m_reset();
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
      m_load = 0; m_count = 0; m_pre = 0; m_phase = 0;
   endtask

   function automatic logic m_sel(input logic [31:0] a);
      return (a & ~32'h1F) == BASE;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      r = 32'd0;
      if (m_sel(a)) begin
         case (a[4:2])
            3'd0: r = {29'd0, m_ie, m_ar, m_en};
            3'd1: r = m_load;
            3'd2: r = m_count;
            3'd3: r = {31'd0, m_exp};
`ifdef TIMER_PRESCALER_EN
            3'd4: r = {16'd0, m_pre};
`endif
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   // one clock of timer behaviour given the store presented in that cycle
   task automatic m_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic        we, tick, expire;
      int          off;
      logic        n_en, n_ar, n_ie, n_exp;
      logic [31:0] n_load, n_count;
      logic [15:0] n_pre, n_phase;
      we  = wr && m_sel(a);
      off = int'(a[4:2]);
`ifdef TIMER_PRESCALER_EN
      // tick on the last clock of each (PRESCALE+1)-clock enabled period
      tick = m_en && (int'(m_phase) == int'(m_pre));
`else
      tick = m_en;
`endif
      expire = tick && (m_count == 0);
      n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
      n_load = m_load; n_count = m_count; n_pre = m_pre;
      n_phase = (m_en && !tick) ? m_phase + 16'd1 : 16'd0;
      if (tick) n_count = (m_count != 0) ? m_count - 1 : (m_ar ? m_load : 32'd0);
      if (expire && !m_ar) n_en = 0;
      if (we && off == 0) begin n_en = d[0]; n_ar = d[1]; n_ie = d[2]; end
      if (we && off == 1) begin n_load = d; if (!m_en) n_count = d; end
      if (we && off == 3 && d[0]) n_exp = 0;
      if (expire) n_exp = 1;
`ifdef TIMER_PRESCALER_EN
      if (we && off == 4) begin n_pre = d[15:0]; n_phase = 0; end
`endif
      m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
      m_load = n_load; m_count = n_count; m_pre = n_pre; m_phase = n_phase;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one bus cycle: drive at falling edge, check outputs, advance model at rising edge
   task automatic op(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdat);
      bus.Mem_Write_i  = wr;
      bus.Mem_Read_i   = rd;
      bus.Address_i    = a;
      bus.Write_Data_i = d;
      #1;
      rdat = bus.Read_Data_o;
      chk("rdata", bus.Read_Data_o, rd ? m_read(a) : 32'd0);
      chk("select", {31'd0, bus.Select_o}, {31'd0, m_sel(a)});
      chk("irq", {31'd0, bus.Irq_o}, {31'd0, m_exp & m_ie});
      @(posedge clk);
      if (!reset) m_reset(); else m_step(wr, a, d);
      @(negedge clk);
   endtask

   task automatic wr_reg(input int off, input logic [31:0] d);
      logic [31:0] tmp;
      op(1'b1, 1'b0, BASE + 32'(off), d, tmp);
   endtask

   task automatic rd_reg(input int off, output logic [31:0] v);
      op(1'b0, 1'b1, BASE + 32'(off), 32'd0, v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      logic        seen;
      int          n;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      m_reset();
      bus.Mem_Write_i = 0; bus.Mem_Read_i = 0; bus.Address_i = 0; bus.Write_Data_i = 0;
      @(negedge clk);

      // reads during reset return reset values
      rd_reg(8, v);
      chk("rst_count_in_reset", v, 32'd0);
      reset = 1'b1;

      // every offset of the window reads 0 after reset
      for (int o = 0; o < 32; o += 4) begin
         rd_reg(o, v);
         chk("rst_read", v, 32'd0);
      end
      chk("rst_irq", {31'd0, bus.Irq_o}, 32'd0);
      op(1'b0, 1'b1, BASE - 32'd4, 32'd0, v);
      chk("sel_below", {31'd0, bus.Select_o}, 32'd0);
      op(1'b0, 1'b1, BASE + 32'h1F, 32'd0, v);
      op(1'b0, 1'b1, BASE + 32'h20, 32'd0, v);
      chk("sel_above_rdata", v, 32'd0);

      // one-shot: LOAD=5 then EN
      wr_reg(4, 32'd5);
      wr_reg(0, 32'h1);
      for (int k = 0; k < 6; k++) begin
         rd_reg(8, v);
         chk("oneshot_count", v, 32'(5 - k));
      end
      rd_reg(12, v);
      chk("oneshot_exp", v, 32'd1);
      rd_reg(0, v);
      chk("oneshot_en_off", v, 32'd0);
      rd_reg(8, v);
      chk("oneshot_count_hold", v, 32'd0);

      // auto-reload with interrupt, period 4
      wr_reg(12, 32'h1);
      wr_reg(4, 32'd3);
      wr_reg(0, 32'h7);
      for (int k = 0; k < 8; k++) begin
         rd_reg(8, v);
         chk("ar_count", v, 32'(3 - (k % 4)));
      end
      chk("ar_irq_high", {31'd0, bus.Irq_o}, 32'd1);
      wr_reg(12, 32'h1);
      chk("ar_irq_low", {31'd0, bus.Irq_o}, 32'd0);
      n = 0;
      while (!(m_en && m_count == 0) && n < 10) begin
         rd_reg(12, v);
         n++;
      end
      chk("ar_find_expire", {31'd0, (m_en && m_count == 0)}, 32'd1);
      wr_reg(12, 32'h1);
      rd_reg(12, v);
      chk("clear_vs_expire", v, 32'd1);

      // LOAD write while running only affects the next reload
      wr_reg(4, 32'd100);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         rd_reg(8, v);
         if (v > 32'd3) seen = 1'b1;
      end
      chk("reload_seen", {31'd0, seen}, 32'd1);
      chk("reload_value", v, 32'd100);
      wr_reg(0, 32'h0);

      // reset mid-count at COUNT=7 with interrupt asserted
      wr_reg(4, 32'd10);
      wr_reg(0, 32'h5);
      n = 0;
      while (m_count != 7 && n < 10) begin
         rd_reg(8, v);
         n++;
      end
      chk("pre_reset_irq", {31'd0, bus.Irq_o}, 32'd1);
      reset = 1'b0;
      m_reset();
      rd_reg(8, v);
      chk("midreset_count", v, 32'd0);
      chk("midreset_irq", {31'd0, bus.Irq_o}, 32'd0);
      reset = 1'b1;
      rd_reg(0, v);
      chk("postreset_ctrl", v, 32'd0);
      rd_reg(12, v);
      chk("postreset_exp", v, 32'd0);

      // prescaler: PRESCALE=2, LOAD=1 -> 6 clocks, or 2 clocks without prescaler
      wr_reg(16, 32'd2);
      wr_reg(4, 32'd1);
      rd_reg(16, v);
`ifdef TIMER_PRESCALER_EN
      chk("prescale_read", v, 32'd2);
`else
      chk("prescale_read", v, 32'd0);
`endif
      wr_reg(0, 32'h1);
      n = 0;
      rd_reg(12, v);
      while (v == 32'd0 && n < 50) begin
         n++;
         rd_reg(12, v);
      end
`ifdef TIMER_PRESCALER_EN
      chk("prescale_clocks", 32'(n), 32'd6);
`else
      chk("prescale_clocks", 32'(n), 32'd2);
`endif

      // random traffic
      for (int i = 0; i < 600; i++) begin
         int          off, r;
         logic [31:0] a, d;
         logic        w, rr;
         r   = int'($urandom_range(0, 9));
         off = int'($urandom_range(0, 7));
         a   = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h20 + 32'($urandom_range(0, 31));
         w  = (r < 3);
         rr = (r >= 3) || ($urandom_range(0, 1) == 1);
         if (off == 1)      d = 32'($urandom_range(0, 6));
         else if (off == 4) d = 32'($urandom_range(0, 3));
         else               d = $urandom;
         op(w, rr, a, d, v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_timer_responder.md
# mmio_timer_responder

Memory-mapped down-counting timer that sits on the responder side of the core's data-memory bus, alongside the data memory. It decodes the core's load and store requests inside a 32-byte address window. Stores update its registers on the clock edge; loads return register contents in the same cycle, as the single-cycle core requires. It raises a level interrupt request when the count expires.

## Interface
- BASE_ADDRESS, 32'h1001_0000: byte base of the 32-byte register window. Must be 32-byte aligned.
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- Mem_Write_i  input  1  store request from the core, qualified by Address_i
- Mem_Read_i  input  1  load request from the core
- Address_i  input  32  byte address (ALU result)
- Write_Data_i  input  32  store data (register-file read port 2)
- Read_Data_o  output  32  load data; combinational
- Select_o  output  1  Address_i[31:5] == BASE_ADDRESS[31:5]; drives the top-level load-data mux; combinational
- Irq_o  output  1  STATUS.EXP & CTRL.IE

## Operation
- Register map (offset = Address_i[4:0]; bits [1:0] are ignored, so access is word-only):
  - 0x00 CTRL, read/write. Bit 0 EN (count enable), bit 1 AR (auto-reload), bit 2 IE (interrupt enable). Other bits read 0.
  - 0x04 LOAD, read/write, 32 bits.
  - 0x08 COUNT, read-only. Writes are ignored.
  - 0x0C STATUS. Bit 0 EXP. Writing 1 clears it; writing 0 has no effect.
  - 0x10 PRESCALE. See Configuration.
  - 0x14–0x1C are reserved: they read 0 and ignore writes.
- Write strobe = Mem_Write_i & Select_o.
- Read_Data_o = selected register when Mem_Read_i & Select_o; otherwise 32'h0.
- Writing LOAD while EN=0 also copies Write_Data_i into COUNT. While EN=1, only LOAD changes.
- Tick: one per clock while EN=1 (or prescaled; see Configuration).
- On a tick with COUNT != 0: COUNT <= COUNT - 1.
- On a tick with COUNT == 0 (expire event):
  - EXP <= 1.
  - If AR=1: COUNT <= LOAD.
  - If AR=0: EN <= 0 and COUNT stays 0.
- Period with AR=1 is LOAD+1 ticks. LOAD=0 with AR=1 expires every tick.
- Setting EN from 0 to 1 does not reload COUNT. Starting with COUNT=0 expires on the first tick.

## Timing
- Reset (reset low, asynchronous) sets: CTRL=0, LOAD=0, COUNT=0, EXP=0, PRESCALE=0, prescaler counter=0.
  - Outputs during reset: Irq_o=0, Read_Data_o=0 unless a load is selected (reads then return reset values).
- A store is visible to a load in the next cycle. A same-cycle load returns the old value.
- Irq_o asserts in the cycle after the expire edge and stays high until EXP is cleared or IE=0.
- Simultaneous events:
  - Expire event and a STATUS write-1-clear in the same cycle: set wins, EXP=1.
  - Expire event with AR=0 (clears EN) and a CTRL write in the same cycle: the software write wins.
  - Tick and a LOAD write with EN=1 in the same cycle: COUNT follows the tick rules; LOAD takes the new value.
- A reset mid-count aborts immediately. No expire is reported.
- Mem_Read_i and Mem_Write_i asserted together: the read returns the old value and the write commits at the edge.

## Configuration
- Macro TIMER_PRESCALER_EN.
- Defined:
  - PRESCALE (0x10) is a 16-bit read/write register; upper bits read 0.
  - An internal 16-bit prescaler counter runs while EN=1 and issues one tick per PRESCALE+1 clocks.
  - The prescaler counter is held at 0 while EN=0 and cleared on any PRESCALE write.
- Undefined:
  - There is no prescaler hardware. A tick occurs every clock while EN=1.
  - Offset 0x10 reads 0 and ignores writes.

## Test plan
- Reset, then load every offset in the window → all read 0. Irq_o=0. Select_o=1 only for BASE_ADDRESS..BASE_ADDRESS+0x1F.
- LOAD=5 with EN=0, then CTRL=0x1 (one-shot) → COUNT reads 5,4,3,2,1,0; EXP=1 on the 6th tick; EN reads 0; COUNT stays 0.
- LOAD=3, CTRL=0x7 (EN, AR, IE) → EXP sets every 4 clocks and Irq_o rises. Write STATUS=1 → Irq_o falls next cycle. Clear issued on the expire cycle → EXP stays 1.
- Write LOAD=100 while counting (EN=1) → COUNT continues from its current value; the next reload uses 100.
- Assert reset low for one cycle mid-count at COUNT=7 → all registers read 0 immediately and Irq_o=0.
- With TIMER_PRESCALER_EN defined: PRESCALE=2, LOAD=1, CTRL=0x1 → expire after 6 clocks. Without it: expire after 2 clocks, and 0x10 reads 0.
